cond_status_unit: RTL and testbench
===================================

Name: cond_status_unit

Overview:
- Multi-lane successor to the single-lane condition checker. Owns the architectural NZCV status register, tracks in-flight flag-setting instructions, and evaluates the 4-bit condition field for LANES issue slots per cycle.
- Sits between decode/issue, which presents conditions, and EXE/WB, which writes status.
- Result is registered: one-cycle latency.
- Raises a combinational hazard when a lane's condition depends on flags not yet produced.

Parameters:
LANES, 2, number of parallel condition-evaluation lanes (1..4)
MAX_INFLIGHT, 3, max outstanding flag-setting instructions tracked (1..7)
BYPASS, 1, 1 = same-cycle status_in forwarded to evaluation; 0 = evaluate from register only
CNT_W, $clog2(MAX_INFLIGHT+1), pending counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
status_we  in  1  flag write from EXE/WB (S-bit instruction completing)
status_in  in  4  new flags; bit0 V, bit1 C, bit2 Z, bit3 N
flush  in  1  pipeline flush; clears pending tracking
issue_s  in  LANES  lane issues a flag-setting instruction this cycle
cond_valid  in  LANES  lane presents a condition for evaluation
cond  in  4*LANES  lane i condition at [4i+3:4i]
hazard  out  LANES  combinational; lane must stall, no result produced
res_valid  out  LANES  registered; result valid for lane
result  out  LANES  registered; 1 = condition passes (execute)
status_q  out  4  architectural flags
pending_cnt  out  CNT_W  outstanding flag writers
ovf_err  out  1  sticky; pending counter saturated

Behaviour:
- Reset (rst high at posedge): status_q=0, pending_cnt=0, res_valid=0, result=0, ovf_err=0; optional counters=0. Reset overrides all other inputs in that cycle.
- Status register: on posedge with status_we, status_q<=status_in. status_we is honoured regardless of flush or pending_cnt.
- Effective flags F: status_in if (BYPASS && status_we), else status_q.
- Condition decode on F:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V)
  - 1110 always 1; 1111 reserved, treated as always 1
- Effective pending P = pending_cnt - (BYPASS && status_we && pending_cnt>0 ? 1 : 0).
- hazard[i] = cond_valid[i] && cond_i not in {1110,1111} && (P>0 || issue_s[j] for any j<i). The second term is the intra-bundle dependency.
- hazard[i] is low whenever cond_valid[i] is low. Lane 0 never sees an intra-bundle hazard.
- Registered output, next cycle: res_valid[i]<=cond_valid[i]&&~hazard[i]; result[i]<=decode(cond_i,F) when that valid is set, else 0.
- Counter next value:
  - flush: 0, plus popcount(issue_s) when issue_s is set the same cycle.
  - otherwise: pending_cnt + popcount(issue_s) - (status_we && pending_cnt>0).
- Underflow: status_we with pending_cnt=0 writes status, counter holds at 0, no error.
- Overflow: next value > MAX_INFLIGHT saturates at MAX_INFLIGHT and sets ovf_err; ovf_err is cleared only by rst.
- Caller asserts issue_s only for instructions that actually issue; the unit does not gate issue_s with hazard.
- flush does not clear res_valid for results already registered; the pipeline discards those.

Optional Feature:
- Macro COND_PERF_EN.
- Defined: adds outputs taken_cnt[31:0] and skipped_cnt[31:0]. Each posedge adds popcount(res_valid&result) and popcount(res_valid&~result) respectively. Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then status_we=1, status_in=4'b0100 -> status_q=0100. Next cycle lane0 cond=0000 valid -> one cycle later res_valid[0]=1, result[0]=1. Lane1 cond=0001 -> result[1]=0.
- BYPASS=1, status_q=0, status_we=1 with status_in=4'b0010 and lane0 cond=0010 in the same cycle -> hazard[0]=0, next cycle result[0]=1. With BYPASS=0 -> result[0]=0.
- issue_s=2'b01 one cycle -> pending_cnt=1. Next cycle lane0 cond=0100, no status_we -> hazard[0]=1, res_valid[0]=0 next cycle. Same cycle lane1 cond=1110 -> hazard[1]=0, result[1]=1.
- Single cycle with issue_s[0]=1 and lane1 cond=1010 -> hazard[1]=1 even with pending_cnt=0.
- MAX_INFLIGHT=3: issue_s=2'b11 for two cycles -> pending_cnt=3, ovf_err=1 and stays 1. Then flush -> pending_cnt=0, ovf_err still 1. Then rst -> ovf_err=0.
- Flag cases with N=1, V=0, Z=0, C=1 -> 1000:1, 1001:0, 1010:0, 1011:1, 1100:0, 1101:1, 1111:1. With COND_PERF_EN, taken_cnt advances by 4 and skipped_cnt by 3 across these 7 results.

Source files
------------

// File: rtl/cond_status_unit.sv
// Multi-lane NZCV condition evaluator: owns the status register, tracks in-flight flag writers.
// Optional taken/skipped performance counters are compiled in with `define COND_PERF_EN.
module cond_status_unit #(
    parameter int  LANES        = 2,
    parameter int  MAX_INFLIGHT = 3,
    parameter int  BYPASS       = 1,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               status_we,
    input  logic [3:0]         status_in,
    input  logic               flush,
    input  logic [LANES-1:0]   issue_s,
    input  logic [LANES-1:0]   cond_valid,
    input  logic [4*LANES-1:0] cond,
    output logic [LANES-1:0]   hazard,
    output logic [LANES-1:0]   res_valid,
    output logic [LANES-1:0]   result,
    output logic [3:0]         status_q,
    output logic [CNT_W-1:0]   pending_cnt,
`ifdef COND_PERF_EN
    output logic [31:0]        taken_cnt,
    output logic [31:0]        skipped_cnt,
`endif
    output logic               ovf_err
);

    // Wide enough for MAX_INFLIGHT plus a full bundle of issues without wrapping.
    localparam int SUM_W = CNT_W + 3;

    logic [3:0]       flags_eff;
    logic             bypass_en;
    logic             retire;
    logic             pend_eff;
    logic             older_issue;
    logic [3:0]       lane_c;
    logic [SUM_W-1:0] sum;
    logic [LANES-1:0] res_valid_d, res_valid_q;
    logic [LANES-1:0] result_d, result_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = !cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cf && !z;
            4'b1001: cond_pass = !cf || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] popcount(input logic [LANES-1:0] v);
        popcount = '0;
        for (int k = 0; k < LANES; k++) begin
            popcount = popcount + SUM_W'(v[k]);
        end
    endfunction

    always_comb begin
        bypass_en   = (BYPASS != 0) && status_we;
        flags_eff   = bypass_en ? status_in : status_q;
        retire      = status_we && (cnt_q != '0);
        // A writer retiring through the bypass this cycle no longer blocks evaluation.
        pend_eff    = (cnt_q > CNT_W'(1)) || ((cnt_q == CNT_W'(1)) && !bypass_en);
        hazard      = '0;
        res_valid_d = '0;
        result_d    = '0;
        lane_c      = '0;
        older_issue = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_c         = cond[4*i +: 4];
            hazard[i]      = cond_valid[i] && (lane_c[3:1] != 3'b111) && (pend_eff || older_issue);
            res_valid_d[i] = cond_valid[i] && !hazard[i];
            result_d[i]    = res_valid_d[i] && cond_pass(lane_c, flags_eff);
            older_issue    = older_issue | issue_s[i];
        end

        if (flush) begin
            sum = popcount(issue_s);
        end else begin
            sum = SUM_W'(cnt_q) + popcount(issue_s) - SUM_W'(retire);
        end
        if (sum > SUM_W'(MAX_INFLIGHT)) begin
            cnt_d = CNT_W'(MAX_INFLIGHT);
            ovf_d = 1'b1;
        end else begin
            cnt_d = CNT_W'(sum);
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= '0;
            result_q    <= '0;
        end else begin
            if (status_we) begin
                status_q <= status_in;
            end
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign pending_cnt = cnt_q;
    assign ovf_err     = ovf_q;

`ifdef COND_PERF_EN
    logic [31:0] taken_q, skipped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q   <= '0;
            skipped_q <= '0;
        end else begin
            taken_q   <= taken_q + 32'(popcount(res_valid_q & result_q));
            skipped_q <= skipped_q + 32'(popcount(res_valid_q & ~result_q));
        end
    end

    assign taken_cnt   = taken_q;
    assign skipped_cnt = skipped_q;
`endif

endmodule

// File: tb/tb_cond_status_unit.sv
// Bench for cond_status_unit: two instances (bypass on/off) against a behavioural model,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_cond_status_unit;

    localparam int LANES = 2;
    localparam int MAXI  = 3;
    localparam int CW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, status_we, flush;
    logic [3:0]         status_in;
    logic [LANES-1:0]   issue_s, cond_valid;
    logic [4*LANES-1:0] cond;

    logic [LANES-1:0] hz_a, rv_a, rs_a, hz_b, rv_b, rs_b;
    logic [3:0]       sq_a, sq_b;
    logic [CW-1:0]    pc_a, pc_b;
    logic             ov_a, ov_b;
`ifdef COND_PERF_EN
    logic [31:0] tk_a, sk_a, tk_b, sk_b;
`endif

    cond_status_unit #(.LANES(LANES), .MAX_INFLIGHT(MAXI), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .status_we(status_we), .status_in(status_in), .flush(flush),
        .issue_s(issue_s), .cond_valid(cond_valid), .cond(cond), .hazard(hz_a),
        .res_valid(rv_a), .result(rs_a), .status_q(sq_a), .pending_cnt(pc_a),
`ifdef COND_PERF_EN
        .taken_cnt(tk_a), .skipped_cnt(sk_a),
`endif
        .ovf_err(ov_a));

    cond_status_unit #(.LANES(LANES), .MAX_INFLIGHT(MAXI), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .status_we(status_we), .status_in(status_in), .flush(flush),
        .issue_s(issue_s), .cond_valid(cond_valid), .cond(cond), .hazard(hz_b),
        .res_valid(rv_b), .result(rs_b), .status_q(sq_b), .pending_cnt(pc_b),
`ifdef COND_PERF_EN
        .taken_cnt(tk_b), .skipped_cnt(sk_b),
`endif
        .ovf_err(ov_b));

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = bypass instance, 1 = register-only instance.
    logic [3:0]  m_st[2];
    int          m_cnt[2];
    bit          m_ovf[2];
    logic [1:0]  m_rv[2], m_rs[2];
    logic [31:0] m_tk[2], m_sk[2];
    logic [1:0]  hz_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Conditions come in pairs: even code is a base predicate, odd code its negation.
    function automatic bit pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        if (c >= 4'd14) return 1'b1;
        case (int'(c) / 2)
            0:       base = z;
            1:       base = cc;
            2:       base = n;
            3:       base = v;
            4:       base = cc && !z;
            5:       base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic int ones(input logic [1:0] x);
        return int'(x[0]) + int'(x[1]);
    endfunction

    task automatic step();
        logic [1:0]  exp_hz[2], n_rv[2], n_rs[2];
        logic [3:0]  n_st[2], f, c;
        int          n_cnt[2], p, pop;
        bit          n_ovf[2], older, byp;
        logic [31:0] n_tk[2], n_sk[2];
        #1;
        pop = ones(issue_s);
        for (int b = 0; b < 2; b++) begin
            byp = (b == 0);
            f   = (byp && status_we) ? status_in : m_st[b];
            p   = m_cnt[b] - ((byp && status_we && m_cnt[b] > 0) ? 1 : 0);
            older = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                c = cond[4*i +: 4];
                exp_hz[b][i] = cond_valid[i] && (c < 4'd14) && (p > 0 || older);
                n_rv[b][i]   = cond_valid[i] && !exp_hz[b][i];
                n_rs[b][i]   = n_rv[b][i] && pass(c, f);
                older        = older || issue_s[i];
            end
            n_cnt[b] = flush ? pop : m_cnt[b] + pop - ((status_we && m_cnt[b] > 0) ? 1 : 0);
            n_ovf[b] = m_ovf[b];
            if (n_cnt[b] > MAXI) begin
                n_cnt[b] = MAXI;
                n_ovf[b] = 1'b1;
            end
            n_st[b] = status_we ? status_in : m_st[b];
            n_tk[b] = m_tk[b] + 32'(ones(m_rv[b] & m_rs[b]));
            n_sk[b] = m_sk[b] + 32'(ones(m_rv[b] & ~m_rs[b]));
            if (rst) begin
                n_rv[b] = '0; n_rs[b] = '0; n_cnt[b] = 0; n_ovf[b] = 1'b0;
                n_st[b] = '0; n_tk[b] = '0; n_sk[b] = '0;
            end
        end
        chk("hazard_byp",   32'(hz_a), 32'(exp_hz[0]));
        chk("hazard_nobyp", 32'(hz_b), 32'(exp_hz[1]));
        hz_last = hz_a;
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            m_rv[b] = n_rv[b]; m_rs[b] = n_rs[b]; m_cnt[b] = n_cnt[b]; m_ovf[b] = n_ovf[b];
            m_st[b] = n_st[b]; m_tk[b] = n_tk[b]; m_sk[b] = n_sk[b];
        end
        chk("res_valid_byp", 32'(rv_a), 32'(m_rv[0]));
        chk("result_byp",    32'(rs_a), 32'(m_rs[0]));
        chk("status_byp",    32'(sq_a), 32'(m_st[0]));
        chk("pending_byp",   32'(pc_a), 32'(m_cnt[0]));
        chk("ovf_byp",       32'(ov_a), 32'(m_ovf[0]));
        chk("res_valid_nobyp", 32'(rv_b), 32'(m_rv[1]));
        chk("result_nobyp",    32'(rs_b), 32'(m_rs[1]));
        chk("status_nobyp",    32'(sq_b), 32'(m_st[1]));
        chk("pending_nobyp",   32'(pc_b), 32'(m_cnt[1]));
        chk("ovf_nobyp",       32'(ov_b), 32'(m_ovf[1]));
`ifdef COND_PERF_EN
        chk("taken_byp",     tk_a, m_tk[0]);
        chk("skipped_byp",   sk_a, m_sk[0]);
        chk("taken_nobyp",   tk_b, m_tk[1]);
        chk("skipped_nobyp", sk_b, m_sk[1]);
`endif
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; status_we = 1'b0; status_in = '0; flush = 1'b0;
        issue_s = '0; cond_valid = '0; cond = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic eval2(input logic [1:0] cv, input logic [3:0] c1, input logic [3:0] c0);
        idle();
        cond_valid = cv;
        cond = {c1, c0};
        step();
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            m_st[b] = '0; m_cnt[b] = 0; m_ovf[b] = 1'b0;
            m_rv[b] = '0; m_rs[b] = '0; m_tk[b] = '0; m_sk[b] = '0;
        end
        hz_last = '0;
        idle();
        @(negedge clk);

        // Reset state
        do_reset();
        chk("lit_reset_status",  32'(sq_a), 32'h0);
        chk("lit_reset_pending", 32'(pc_a), 32'h0);
        chk("lit_reset_rv",      32'(rv_a), 32'h0);
        chk("lit_reset_ovf",     32'(ov_a), 32'h0);

        // Status write then EQ / NE
        idle(); status_we = 1'b1; status_in = 4'b0100; step();
        chk("lit_status_write", 32'(sq_a), 32'h4);
        eval2(2'b11, 4'b0001, 4'b0000);
        chk("lit_eq_ne_rv",  32'(rv_a), 32'h3);
        chk("lit_eq_ne_res", 32'(rs_a), 32'h1);

        // Same-cycle bypass versus register-only
        do_reset();
        idle(); status_we = 1'b1; status_in = 4'b0010; cond_valid = 2'b01; cond = {4'b0000, 4'b0010};
        step();
        chk("lit_bypass_hz",    32'(hz_last), 32'h0);
        chk("lit_bypass_res",   32'(rs_a), 32'h1);
        chk("lit_nobypass_res", 32'(rs_b), 32'h0);

        // Pending writer blocks lane 0, AL on lane 1 proceeds
        idle(); issue_s = 2'b01; step();
        chk("lit_pending_one", 32'(pc_a), 32'h1);
        eval2(2'b11, 4'b1110, 4'b0100);
        chk("lit_pending_hz",  32'(hz_last), 32'h1);
        chk("lit_pending_rv",  32'(rv_a), 32'h2);
        chk("lit_pending_res", 32'(rs_a), 32'h2);

        // Intra-bundle dependency
        do_reset();
        idle(); issue_s = 2'b01; cond_valid = 2'b10; cond = {4'b1010, 4'b0000}; step();
        chk("lit_intra_hz", 32'(hz_last), 32'h2);

        // Saturation, sticky overflow, flush, reset
        do_reset();
        idle(); issue_s = 2'b11; step();
        chk("lit_sat_first", 32'(pc_a), 32'h2);
        step();
        chk("lit_sat_cnt", 32'(pc_a), 32'h3);
        chk("lit_sat_ovf", 32'(ov_a), 32'h1);
        idle(); flush = 1'b1; step();
        chk("lit_flush_cnt", 32'(pc_a), 32'h0);
        chk("lit_flush_ovf", 32'(ov_a), 32'h1);
        do_reset();
        chk("lit_rst_ovf", 32'(ov_a), 32'h0);

        // N=1 Z=0 C=1 V=0 against the compound conditions
        idle(); status_we = 1'b1; status_in = 4'b1010; step();
        eval2(2'b11, 4'b1001, 4'b1000);
        chk("lit_hi_ls", 32'(rs_a), 32'h1);
        eval2(2'b11, 4'b1011, 4'b1010);
        chk("lit_ge_lt", 32'(rs_a), 32'h2);
        eval2(2'b11, 4'b1101, 4'b1100);
        chk("lit_gt_le", 32'(rs_a), 32'h2);
        eval2(2'b01, 4'b0000, 4'b1111);
        chk("lit_nv_rv",  32'(rv_a), 32'h1);
        chk("lit_nv_res", 32'(rs_a), 32'h1);
        idle(); step();
`ifdef COND_PERF_EN
        chk("lit_perf_taken",   tk_a, 32'd4);
        chk("lit_perf_skipped", sk_a, 32'd3);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            status_we  = ($urandom_range(0, 2) == 0);
            status_in  = 4'($urandom);
            issue_s    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            cond_valid = 2'($urandom);
            cond       = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
